perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Synthesizable, parametrised event-counter bank for processor performance statistics.
//  Counts per-cycle event strobes from proc_hier: retire, I$ req/hit, D$ req/hit.
//  Also keeps a free-running cycle count, freezes on halt and gives a registered read port.
//  Sits beside the core so that counts survive into FPGA/post-synthesis runs; the bench reads them back.
// PARAMETERS
//  NUM_EVT  6   number of event channels (1..16); cycle counter is extra index NUM_EVT
//  CNT_W    32  counter width in bits (8..64)
//  SEL_W    $clog2(NUM_EVT+1)  read-select width (derived, do not override)
// PORTS
//  clk       in   1         system clock
//  rst       in   1         synchronous reset, active-high
//  evt       in   NUM_EVT   per-cycle event strobes; bit i increments channel i
//  halt      in   1         processor halt strobe (Halt in Memory/WB)
//  clr       in   1         synchronous clear of all counters and overflow flags
//  rd_en     in   1         read request
//  rd_sel    in   SEL_W     channel to read; NUM_EVT selects the cycle counter
//  rd_data   out  CNT_W     registered read data
//  rd_valid  out  1         rd_data valid; one-cycle pulse
//  ovf       out  NUM_EVT+1 sticky per-channel overflow flags
//  frozen    out  1         high while in FROZEN state
// BEHAVIOUR
//  Reset: state=RUN; all counters=0; ovf=0; rd_data=0; rd_valid=0; frozen=0.
//  FSM (2 states):
//   RUN    -> FROZEN on halt & ~clr.
//   FROZEN -> RUN on clr.
//   FROZEN ignores evt and halt.
//  Counting happens in RUN only. Channel i gets +1 on cycles where evt[i]=1; cycle counter gets +1 every RUN cycle.
//  The halt cycle itself is counted: evt bits and the cycle tick on that edge are applied, then the FSM freezes.
//  clr in either state: all counters=0, ovf=0 on next edge. clr beats a same-cycle evt, so the count is 0, not 1.
//   clr with halt in RUN: counters cleared, state stays RUN.
//  Overflow: an increment from all-ones sets ovf[i] (sticky until clr/rst); for the counter value see CONFIGURATION.
//  Read: rd_en sampled at edge N -> rd_data/rd_valid at edge N+1 (latency 1).
//   rd_data holds the counter value before edge N's update.
//   A read and a clr in the same cycle return the pre-clear value.
//   rd_sel > NUM_EVT returns 0 with rd_valid=1.
//   Reads are legal in both states and do not disturb counting.
//  rd_data holds its last value when rd_en=0; rd_valid=0 then.
//  Arithmetic: unsigned CNT_W-bit, one adder per channel; no multi-increment per cycle.
//  rst mid-operation: everything returns to reset values on that edge; a pending read is dropped (rd_valid=0).
// CONFIGURATION
//  PERF_SATURATE_EN defined: counters saturate at {CNT_W{1'b1}}; ovf[i] still sets on the first blocked increment.
//  PERF_SATURATE_EN undefined: counters wrap to 0; ovf[i] sets on the wrap.
// STRUCTURE
//  perf_pkg:
//   state enum {PERF_RUN, PERF_FROZEN}
//   event index constants EVT_RETIRE=0, EVT_ICREQ=1, EVT_ICHIT=2, EVT_DCREQ=3, EVT_DCHIT=4, EVT_HALT=5
//  Sub-module perf_cnt_slice (one counter + sticky ovf):
//   inputs clk, rst, clr, inc
//   outputs cnt, ovf
//   generated NUM_EVT+1 times
//  Top level holds the FSM, the read mux and the output registers.
// TESTING
//  T1 reset/count:
//   rst 2 cycles, then evt=6'b000001 for 10 cycles, then 0.
//   rd_sel=0 -> rd_data=10, rd_valid one cycle after rd_en.
//   rd_sel=6 -> cycle count equals cycles since rst deasserted.
//  T2 halt freeze:
//   evt[1]=1 continuously, halt at cycle 20.
//   ch1=20 (halt cycle counted); frozen=1; ch1 still 20 after 50 more cycles.
//  T3 clr collisions:
//   clr+evt[2] same cycle -> ch2=0.
//   rd_en+clr same cycle -> rd_data=pre-clear value; next read returns 0.
//   In FROZEN, clr -> frozen=0, counting resumes.
//  T4 overflow, CNT_W=8:
//   300 evt[3] pulses, ovf[3]=1 at the 256th.
//   PERF_SATURATE_EN: ch3=255. Without it: ch3=44.
//  T5 bad select/rst:
//   rd_sel=7 with NUM_EVT=6 -> rd_data=0, rd_valid=1.
//   rst asserted in the cycle after rd_en -> rd_valid=0, all counters=0.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// Shared types and event-channel indices for the performance counter bank.
package perf_pkg;

   typedef enum logic [0:0] {
      PERF_RUN    = 1'b0,
      PERF_FROZEN = 1'b1
   } perf_state_e;

   localparam int EVT_RETIRE = 0;
   localparam int EVT_ICREQ  = 1;
   localparam int EVT_ICHIT  = 2;
   localparam int EVT_DCREQ  = 3;
   localparam int EVT_DCHIT  = 4;
   localparam int EVT_HALT   = 5;

endpackage

// File: rtl/perf_counter_bank_cnt_slice.sv
// One event counter with a sticky overflow flag.
// PERF_SATURATE_EN: defined -> counter saturates at all-ones; undefined -> counter wraps.
module perf_cnt_slice
   import perf_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             at_max;

   always_comb begin
      at_max = &cnt_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      // clr wins over a same-cycle increment
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc) begin
         if (at_max) begin
            ovf_d = 1'b1;
`ifdef PERF_SATURATE_EN
            cnt_d = cnt_q;
`else
            cnt_d = '0;
`endif
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank: NUM_EVT event channels plus a cycle counter, halt freeze, registered read port.
// Overflow behaviour of each slice is selected by PERF_SATURATE_EN (see perf_cnt_slice).
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_EVT = 6,
   parameter int CNT_W   = 32,
   parameter int SEL_W   = $clog2(NUM_EVT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_EVT-1:0] evt,
   input  logic               halt,
   input  logic               clr,
   input  logic               rd_en,
   input  logic [SEL_W-1:0]   rd_sel,
   output logic [CNT_W-1:0]   rd_data,
   output logic               rd_valid,
   output logic [NUM_EVT:0]   ovf,
   output logic               frozen
);

   perf_state_e      state_q, state_d;
   logic             run;
   logic [NUM_EVT:0] inc_w;
   logic [NUM_EVT:0] ovf_w;
   logic [CNT_W-1:0] cnt_w [NUM_EVT+1];
   logic [CNT_W-1:0] rd_mux;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   assign run   = (state_q == PERF_RUN);
   // the top index is the cycle counter, ticking on every RUN cycle
   assign inc_w = {run, evt & {NUM_EVT{run}}};

   for (genvar g = 0; g <= NUM_EVT; g++) begin : g_slice
      perf_cnt_slice #(
         .CNT_W(CNT_W)
      ) u_slice (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .inc (inc_w[g]),
         .cnt (cnt_w[g]),
         .ovf (ovf_w[g])
      );
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = PERF_RUN;
      end else if (run && halt) begin
         state_d = PERF_FROZEN;
      end
   end

   // out-of-range selects fall through to zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i <= NUM_EVT; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_mux = cnt_w[i];
         end
      end
   end

   always_comb begin
      rd_data_d  = rd_en ? rd_mux : rd_data_q;
      rd_valid_d = rd_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PERF_RUN;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign ovf      = ovf_w;
   assign frozen   = (state_q == PERF_FROZEN);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank (NUM_EVT=6, CNT_W=8) with a count-based reference model.
module tb_perf_counter_bank;

   localparam int NE = 6;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NE-1:0] evt;
   logic          halt;
   logic          clr;
   logic          rd_en;
   logic [2:0]    rd_sel;
   logic [CW-1:0] rd_data;
   logic          rd_valid;
   logic [NE:0]   ovf;
   logic          frozen;

   perf_counter_bank #(
      .NUM_EVT(NE),
      .CNT_W  (CW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .evt     (evt),
      .halt    (halt),
      .clr     (clr),
      .rd_en   (rd_en),
      .rd_sel  (rd_sel),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .ovf     (ovf),
      .frozen  (frozen)
   );

   always #5 clk = ~clk;

   // Model: true number of counted events per channel (unbounded), then mapped to CNT_W bits
   int            n_evt [NE+1];
   bit            m_frozen;
   logic [CW-1:0] last_rd;
   int            edge_n;
   bit            started;
   int            n_checks;
   int            n_fail;

   typedef struct {
      int            out_edge;
      logic [CW-1:0] data;
   } rd_t;
   rd_t exp_q[$];

   function automatic logic [CW-1:0] model_val(int i);
      int lim;
      lim = (1 << CW) - 1;
`ifdef PERF_SATURATE_EN
      return (n_evt[i] > lim) ? CW'(lim) : CW'(n_evt[i]);
`else
      return CW'(n_evt[i] % (lim + 1));
`endif
   endfunction

   function automatic logic [NE:0] model_ovf();
      logic [NE:0] o;
      for (int i = 0; i <= NE; i++) o[i] = (n_evt[i] >= (1 << CW));
      return o;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic cyc(input logic [NE-1:0] e, input logic h, input logic c,
                      input logic re, input logic [2:0] rs, input logic r);
      rd_t ent;
      evt = e; halt = h; clr = c; rd_en = re; rd_sel = rs; rst = r;
      if (re && !r) begin
         ent.out_edge = edge_n + 1;
         ent.data     = (int'(rs) <= NE) ? model_val(int'(rs)) : '0;
         exp_q.push_back(ent);
      end
      @(posedge clk);
      edge_n++;
      if (r || c) begin
         for (int i = 0; i <= NE; i++) n_evt[i] = 0;
         m_frozen = 1'b0;
         if (r) last_rd = '0;
      end else if (!m_frozen) begin
         for (int i = 0; i < NE; i++) if (e[i]) n_evt[i]++;
         n_evt[NE]++;
         if (h) m_frozen = 1'b1;
      end
      started = 1'b1;
      #1;
   endtask

   always @(negedge clk) begin
      rd_t ent;
      if (started) begin
         chk("frozen", 64'(frozen), 64'(m_frozen));
         chk("ovf", 64'(ovf), 64'(model_ovf()));
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               chk("rd_valid_spurious", 64'(rd_valid), 64'(0));
            end else begin
               ent = exp_q.pop_front();
               chk("rd_latency_edge", 64'(edge_n), 64'(ent.out_edge));
               chk("rd_data", 64'(rd_data), 64'(ent.data));
               last_rd = ent.data;
            end
         end else begin
            chk("rd_data_hold", 64'(rd_data), 64'(last_rd));
            if (exp_q.size() > 0 && exp_q[0].out_edge <= edge_n) begin
               chk("rd_valid_missing", 64'(rd_valid), 64'(1));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i <= NE; i++) n_evt[i] = 0;
      m_frozen = 1'b0; last_rd = '0; edge_n = 0; started = 1'b0;
      n_checks = 0; n_fail = 0;
      evt = '0; halt = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_sel = '0; rst = 1'b1;

      // reset and basic counting on channel 0
      repeat (2) cyc('0, 0, 0, 0, 3'd0, 1);
      repeat (10) cyc(6'b000001, 0, 0, 0, 3'd0, 0);
      cyc('0, 0, 0, 1, 3'd0, 0);
      cyc('0, 0, 0, 1, 3'd6, 0);
      cyc('0, 0, 0, 0, 3'd0, 0);

      // halt freeze: halt on the 20th counting cycle
      repeat (2) cyc('0, 0, 0, 0, 3'd0, 1);
      repeat (19) cyc(6'b000010, 0, 0, 0, 3'd0, 0);
      cyc(6'b000010, 1, 0, 0, 3'd0, 0);
      cyc(6'b000010, 0, 0, 1, 3'd1, 0);
      repeat (50) cyc(6'b000010, 1, 0, 0, 3'd0, 0);
      cyc(6'b000010, 0, 0, 1, 3'd1, 0);
      cyc('0, 0, 0, 1, 3'd6, 0);

      // clr collisions, including clr out of FROZEN
      cyc(6'b000100, 0, 1, 0, 3'd0, 0);
      cyc('0, 0, 0, 1, 3'd2, 0);
      repeat (5) cyc(6'b000100, 0, 0, 0, 3'd0, 0);
      cyc('0, 0, 1, 1, 3'd2, 0);
      cyc('0, 0, 0, 1, 3'd2, 0);
      cyc(6'b000100, 1, 1, 0, 3'd0, 0);
      cyc(6'b000100, 1, 0, 0, 3'd0, 0);
      repeat (3) cyc(6'b000100, 0, 0, 0, 3'd0, 0);
      cyc('0, 0, 1, 0, 3'd0, 0);
      repeat (4) cyc(6'b000100, 0, 0, 0, 3'd0, 0);
      cyc('0, 0, 0, 1, 3'd2, 0);

      // overflow on channel 3
      cyc('0, 0, 0, 0, 3'd0, 1);
      repeat (300) cyc(6'b001000, 0, 0, 0, 3'd0, 0);
      cyc('0, 0, 0, 1, 3'd3, 0);
      cyc('0, 0, 0, 0, 3'd0, 0);
`ifdef PERF_SATURATE_EN
      chk("ch3_after_300", 64'(rd_data), 64'd255);
`else
      chk("ch3_after_300", 64'(rd_data), 64'd44);
`endif

      // bad select, then reset right after a read
      cyc('0, 0, 0, 1, 3'd7, 0);
      cyc('0, 0, 0, 1, 3'd3, 0);
      cyc('0, 0, 0, 0, 3'd0, 1);
      chk("rd_valid_after_rst", 64'(rd_valid), 64'(0));
      chk("rd_data_after_rst", 64'(rd_data), 64'(0));
      cyc('0, 0, 0, 1, 3'd3, 0);
      cyc('0, 0, 0, 1, 3'd6, 0);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         cyc(NE'($urandom),
             ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 2) == 0),
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 199) == 0));
      end

      repeat (3) cyc('0, 0, 0, 0, 3'd0, 0);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
